iddr_word_align: RTL and testbench
==================================

IDDR_WORD_ALIGN -- requirements
Module: iddr_word_align

Interface
REQ-001 SHALL have parameter TRAIN, default 4'b0011: expected training nibble {Q3,Q2,Q1,Q0}.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: wait cycles after each slip; legal range 1..15.
REQ-003 SHALL have parameter MATCH_CNT, default 8: consecutive matches needed for lock; legal range 1..255.
REQ-004 SHALL have parameter MAX_SLIPS, default 7: slip attempts allowed before failure; legal range 0..15.
REQ-005 SHALL have the port SCLK  input  1  sole clock, rising edge; same SCLK as the upstream deserializer.
REQ-006 SHALL have the port RSTN  input  1  asynchronous active-low reset.
REQ-007 SHALL have the port START  input  1  begin or restart an alignment search.
REQ-008 SHALL have the ports Q0, Q1, Q2, Q3  input  1 each  deserializer outputs; Q0 is the earliest bit.
REQ-009 SHALL have the port ALIGNWD  output  1  slip request to the deserializer.
REQ-010 SHALL have the port LOCKED  output  1  alignment achieved.
REQ-011 SHALL have the port ERR  output  1  search exhausted without lock.
REQ-012 SHALL have the port SLIP_CNT  output  4  slips issued in the current search.
REQ-013 SHALL have the ports DATA  output  8  assembled byte; DATA_VALID  output  1  one-cycle strobe for DATA.

Function
REQ-014 SHALL form nibble N = {Q3,Q2,Q1,Q0}, sampled every SCLK edge.
REQ-015 SHALL implement the states IDLE, SETTLE, CHECK, SLIP, LOCK and FAIL.
REQ-016 SHALL, in IDLE with START=1, clear SLIP_CNT and the match counter, load the settle counter, and go to SETTLE.
REQ-017 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, ignoring N, then go to CHECK with the match counter at 0.
REQ-018 SHALL, in CHECK with N==TRAIN, increment the match counter; when this match is the MATCH_CNT-th consecutive one, go to LOCK.
REQ-019 SHALL, in CHECK with N!=TRAIN, go to FAIL if SLIP_CNT==MAX_SLIPS, else go to SLIP.
REQ-020 SHALL stay in SLIP for exactly one cycle, drive ALIGNWD=1 only in that cycle, increment SLIP_CNT, then go to SETTLE.
REQ-021 SHALL drive ALIGNWD, LOCKED and ERR as registered state decodes (glitch-free): LOCKED=1 only in LOCK, ERR=1 only in FAIL.
REQ-022 SHALL ignore START in SETTLE, CHECK and SLIP.
REQ-023 SHALL, in LOCK or FAIL with START=1, clear LOCKED, ERR, SLIP_CNT and the match counter, and restart at SETTLE.
REQ-024 SHALL, with MAX_SLIPS=0, go to FAIL on the first mismatch without pulsing ALIGNWD.
REQ-025 SHALL maintain a byte-phase bit that is 0 in the first LOCK cycle and toggles each LOCK cycle.
REQ-026 SHALL, in LOCK with phase 0, hold N as the low nibble.
REQ-027 SHALL, in LOCK with phase 1, register DATA={N, held low nibble} and assert DATA_VALID for the following cycle only.
REQ-028 SHALL hold DATA between strobes, and SHALL keep DATA_VALID=0 outside LOCK, including the cycle after leaving LOCK.
REQ-029 SHALL give a lock latency, with no slips, of LOCKED high after edge E0+SETTLE_CYCLES+MATCH_CNT, where E0 is the edge sampling START.
REQ-030 SHALL give a first DATA_VALID two cycles after LOCKED rises, then one strobe every 2 cycles.

Reset
REQ-031 SHALL, with RSTN=0, immediately force: state IDLE, ALIGNWD=0, LOCKED=0, ERR=0, SLIP_CNT=0, DATA=0, DATA_VALID=0, all counters and the phase bit to 0.
REQ-032 SHALL, after RSTN releases, remain in IDLE until START is sampled high; a mid-search reset abandons the search with no further ALIGNWD pulse.

Verification
REQ-033 SHALL pass: aligned input N=0x3 constant, START pulse -> LOCKED high 12 edges after START, ALIGNWD never high, SLIP_CNT=0.
REQ-034 SHALL pass: the model rotates N by one per ALIGNWD and needs 3 slips -> exactly 3 one-cycle ALIGNWD pulses, each at least 6 cycles apart, SLIP_CNT=3, LOCKED=1.
REQ-035 SHALL pass: N=0x0 constant -> 7 ALIGNWD pulses, then ERR=1, LOCKED=0, SLIP_CNT=7; a START pulse in FAIL restarts with ERR=0 and SLIP_CNT=0.
REQ-036 SHALL pass: N=0x3 for 7 cycles, then 0x0 -> match counter clears, one ALIGNWD pulse, SLIP_CNT=1, back to SETTLE.
REQ-037 SHALL pass: after lock, N alternating 0x5, 0xA -> DATA=0xA5 with DATA_VALID high one cycle in every two.
REQ-038 SHALL pass: RSTN low in mid-CHECK -> all outputs 0 with no clock edge; after release, START=0 for 20 cycles -> still IDLE, ALIGNWD=0.

Source files
------------

// File: rtl/iddr_word_align.sv
// iddr_word_align: searches for the 4:1 deserializer word boundary by pulsing ALIGNWD until
// the training nibble repeats MATCH_CNT times, then pairs locked nibbles into bytes.
module iddr_word_align #(
   parameter logic [3:0] TRAIN         = 4'b0011,
   parameter int         SETTLE_CYCLES = 4,
   parameter int         MATCH_CNT     = 8,
   parameter int         MAX_SLIPS     = 7
) (
   input  logic       SCLK,
   input  logic       RSTN,
   input  logic       START,
   input  logic       Q0,
   input  logic       Q1,
   input  logic       Q2,
   input  logic       Q3,
   output logic       ALIGNWD,
   output logic       LOCKED,
   output logic       ERR,
   output logic [3:0] SLIP_CNT,
   output logic [7:0] DATA,
   output logic       DATA_VALID
);
   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCK, FAIL} state_t;
   localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYCLES);
   localparam logic [7:0] LAST_MATCH = 8'(MATCH_CNT - 1);
   localparam logic [3:0] SLIPS_L = 4'(MAX_SLIPS);
   state_t     state_q, state_d;
   logic [3:0] settle_q, settle_d, slip_q, slip_d, low_q, low_d, nib;
   logic [7:0] match_q, match_d, data_q, data_d;
   logic       phase_q, phase_d, valid_q, valid_d, stay_lock;
   logic       alignwd_q, alignwd_d, locked_q, locked_d, err_q, err_d;
   assign nib = {Q3, Q2, Q1, Q0};
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      slip_d   = slip_q;
      match_d  = match_q;
      case (state_q)
         IDLE, LOCK, FAIL:
            if (START) begin
               state_d  = SETTLE;
               settle_d = SETTLE_L;
               slip_d   = '0;
               match_d  = '0;
            end
         SETTLE:
            if (settle_q == 4'd1) begin
               state_d = CHECK;
               match_d = '0;
            end else
               settle_d = settle_q - 4'd1;
         CHECK:
            if (nib == TRAIN) begin
               state_d = (match_q == LAST_MATCH) ? LOCK : CHECK;
               match_d = match_q + 8'd1;
            end else begin
               match_d = '0;
               state_d = (slip_q == SLIPS_L) ? FAIL : SLIP;
               slip_d  = (slip_q == SLIPS_L) ? slip_q : slip_q + 4'd1;
            end
         SLIP: begin
            state_d  = SETTLE;
            settle_d = SETTLE_L;
         end
         default: state_d = IDLE;
      endcase
   end
   // Byte assembly only runs while lock persists; a restart from LOCK never emits a strobe.
   always_comb begin
      stay_lock = (state_q == LOCK) && (state_d == LOCK);
      phase_d   = stay_lock && !phase_q;
      low_d     = (stay_lock && !phase_q) ? nib : low_q;
      valid_d   = stay_lock && phase_q;
      data_d    = valid_d ? {nib, low_q} : data_q;
      alignwd_d = state_d == SLIP;
      locked_d  = state_d == LOCK;
      err_d     = state_d == FAIL;
   end
   always_ff @(posedge SCLK or negedge RSTN)
      if (!RSTN) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         slip_q    <= '0;
         match_q   <= '0;
         low_q     <= '0;
         data_q    <= '0;
         phase_q   <= 1'b0;
         valid_q   <= 1'b0;
         alignwd_q <= 1'b0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         slip_q    <= slip_d;
         match_q   <= match_d;
         low_q     <= low_d;
         data_q    <= data_d;
         phase_q   <= phase_d;
         valid_q   <= valid_d;
         alignwd_q <= alignwd_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
      end
   assign ALIGNWD    = alignwd_q;
   assign LOCKED     = locked_q;
   assign ERR        = err_q;
   assign SLIP_CNT   = slip_q;
   assign DATA       = data_q;
   assign DATA_VALID = valid_q;
endmodule

// File: tb/tb_iddr_word_align.sv
// tb_iddr_word_align: drives a rotating-boundary deserializer model and checks lock timing,
// slip counts, failure, restart, reset and byte pairing against arithmetic expectations.
module tb_iddr_word_align;
   localparam logic [3:0] TRAIN = 4'b0011;
   localparam int S = 4, M = 8, MS = 7;
   logic SCLK = 1'b0, RSTN = 1'b1, START = 1'b0;
   logic [3:0] n = 4'h0;
   logic ALIGNWD, LOCKED, ERR, DATA_VALID, aw2, lk2, er2, dv2;
   logic [3:0] SLIP_CNT, sc2;
   logic [7:0] DATA, d2;
   int checks = 0, errors = 0, cyc = 0, pulses = 0, pulses2 = 0, lock_k = 0, off = 0, e0 = 0;
   int pq[$];
   bit rot_mode = 1'b0;
   logic [3:0] prev_n = 4'h0;
   logic [7:0] exp_data = 8'h00;
   logic exp_valid = 1'b0;

   iddr_word_align dut (
      .SCLK(SCLK), .RSTN(RSTN), .START(START),
      .Q0(n[0]), .Q1(n[1]), .Q2(n[2]), .Q3(n[3]),
      .ALIGNWD(ALIGNWD), .LOCKED(LOCKED), .ERR(ERR), .SLIP_CNT(SLIP_CNT),
      .DATA(DATA), .DATA_VALID(DATA_VALID)
   );
   iddr_word_align #(.SETTLE_CYCLES(1), .MATCH_CNT(1), .MAX_SLIPS(0)) dut0 (
      .SCLK(SCLK), .RSTN(RSTN), .START(START),
      .Q0(n[0]), .Q1(n[1]), .Q2(n[2]), .Q3(n[3]),
      .ALIGNWD(aw2), .LOCKED(lk2), .ERR(er2), .SLIP_CNT(sc2),
      .DATA(d2), .DATA_VALID(dv2)
   );

   always #5 SCLK = ~SCLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [3:0] rot(input logic [3:0] v, input int k);
      logic [3:0] r;
      r = v;
      for (int i = 0; i < k; i++) r = {r[2:0], r[3]};
      return r;
   endfunction

   // One clock edge: the deserializer slips on edges that see ALIGNWD, and every locked
   // pair of nibbles (earlier one low) must appear as a byte after the second one.
   task automatic tick();
      logic lk, st, aw, a2;
      logic [3:0] nn;
      lk = LOCKED; st = START; aw = ALIGNWD; a2 = aw2; nn = n;
      @(posedge SCLK);
      #1;
      cyc++;
      if (aw) begin
         pulses++;
         off = (off + 1) % 4;
         pq.push_back(cyc);
      end
      if (a2) pulses2++;
      if (rot_mode) n = rot(TRAIN, off);
      if (lk && !st) begin
         lock_k++;
         exp_valid = (lock_k % 2 == 0);
         if (exp_valid) exp_data = {nn, prev_n};
         prev_n = nn;
      end else begin
         lock_k = 0;
         exp_valid = 1'b0;
      end
      checks++;
      if (DATA_VALID !== exp_valid) begin
         errors++;
         $display("FAIL data_valid @%0d: got %0b want %0b", cyc, DATA_VALID, exp_valid);
      end
      checks++;
      if (DATA !== exp_data) begin
         errors++;
         $display("FAIL data @%0d: got %0h want %0h", cyc, DATA, exp_data);
      end
      if (aw) begin
         checks++;
         if (ALIGNWD !== 1'b0) begin
            errors++;
            $display("FAIL alignwd_width @%0d: got %0b want 0", cyc, ALIGNWD);
         end
      end
   endtask

   task automatic start_pulse();
      START = 1'b1;
      tick();
      START = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_lock(input int budget, output int at);
      for (int i = 0; i < budget && LOCKED !== 1'b1; i++) tick();
      at = (LOCKED === 1'b1) ? cyc : -1000;
   endtask

   task automatic test_reset();
      n = TRAIN;
      #3 RSTN = 1'b0;
      #1;
      checks++;
      if ({ALIGNWD, LOCKED, ERR, SLIP_CNT, DATA, DATA_VALID} !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %0h want 0", {ALIGNWD, LOCKED, ERR, SLIP_CNT, DATA, DATA_VALID});
      end
      repeat (3) tick();
      RSTN = 1'b1;
      repeat (5) tick();
      checks++;
      if ({LOCKED, ERR, SLIP_CNT} !== 6'h0 || pulses != 0) begin
         errors++;
         $display("FAIL idle_after_reset: got %0h/%0d want 0/0", {LOCKED, ERR, SLIP_CNT}, pulses);
      end
   endtask

   task automatic test_aligned();
      int p0;
      rot_mode = 1'b1; off = 0; n = TRAIN;
      p0 = pulses;
      start_pulse();
      repeat (S + M - 1) tick();
      checks++;
      if (LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL lock_early: got %0b want 0", LOCKED);
      end
      tick();
      checks++;
      if (LOCKED !== 1'b1 || SLIP_CNT !== 4'd0 || pulses != p0) begin
         errors++;
         $display("FAIL lock_latency: got L=%0b slips=%0d pulses=%0d want 1/0/0", LOCKED, SLIP_CNT, pulses - p0);
      end
   endtask

   task automatic test_settle_ignore();
      rot_mode = 1'b0;
      n = 4'($urandom);
      start_pulse();
      checks++;
      if (LOCKED !== 1'b0 || ERR !== 1'b0) begin
         errors++;
         $display("FAIL restart_from_lock: got L=%0b E=%0b want 0/0", LOCKED, ERR);
      end
      for (int i = 0; i < S; i++) begin
         n = 4'($urandom);
         tick();
      end
      n = TRAIN;
      repeat (M - 1) tick();
      checks++;
      if (LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL settle_lock_early: got %0b want 0", LOCKED);
      end
      tick();
      checks++;
      if (LOCKED !== 1'b1 || SLIP_CNT !== 4'd0) begin
         errors++;
         $display("FAIL settle_ignore: got L=%0b slips=%0d want 1/0", LOCKED, SLIP_CNT);
      end
   endtask

   task automatic test_slips();
      int p0, t;
      rot_mode = 1'b1; off = 1; n = rot(TRAIN, 1);
      p0 = pulses;
      start_pulse();
      pq.delete();
      wait_lock(80, t);
      checks++;
      if (t - e0 != 3 * (S + 2) + S + M) begin
         errors++;
         $display("FAIL slip_lock_time: got %0d want %0d", t - e0, 3 * (S + 2) + S + M);
      end
      checks++;
      if (pulses - p0 != 3 || SLIP_CNT !== 4'd3) begin
         errors++;
         $display("FAIL slip_count: got pulses=%0d cnt=%0d want 3/3", pulses - p0, SLIP_CNT);
      end
      for (int i = 1; i < pq.size(); i++) begin
         checks++;
         if (pq[i] - pq[i-1] != S + 2) begin
            errors++;
            $display("FAIL slip_gap: got %0d want %0d", pq[i] - pq[i-1], S + 2);
         end
      end
   endtask

   task automatic test_fail();
      int p0, t;
      rot_mode = 1'b0; n = 4'h0;
      p0 = pulses;
      start_pulse();
      for (int i = 0; i < 100 && ERR !== 1'b1; i++) tick();
      t = (ERR === 1'b1) ? cyc : -1000;
      checks++;
      if (t - e0 != (MS + 1) * (S + 1) + MS) begin
         errors++;
         $display("FAIL err_time: got %0d want %0d", t - e0, (MS + 1) * (S + 1) + MS);
      end
      checks++;
      if (pulses - p0 != MS || SLIP_CNT !== 4'(MS) || LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL err_state: got pulses=%0d cnt=%0d L=%0b want 7/7/0", pulses - p0, SLIP_CNT, LOCKED);
      end
      n = TRAIN;
      start_pulse();
      checks++;
      if (ERR !== 1'b0 || SLIP_CNT !== 4'd0) begin
         errors++;
         $display("FAIL restart_from_fail: got E=%0b cnt=%0d want 0/0", ERR, SLIP_CNT);
      end
      wait_lock(30, t);
      checks++;
      if (t - e0 != S + M) begin
         errors++;
         $display("FAIL relock_time: got %0d want %0d", t - e0, S + M);
      end
   endtask

   task automatic test_partial(input int k);
      int t;
      rot_mode = 1'b0; n = TRAIN;
      start_pulse();
      repeat (S + k) tick();
      do n = 4'($urandom); while (n == TRAIN);
      tick();
      checks++;
      if (ALIGNWD !== 1'b1 || SLIP_CNT !== 4'd1) begin
         errors++;
         $display("FAIL partial_slip k=%0d: got A=%0b cnt=%0d want 1/1", k, ALIGNWD, SLIP_CNT);
      end
      n = TRAIN;
      wait_lock(40, t);
      checks++;
      if (t - e0 != 2 * S + M + k + 2) begin
         errors++;
         $display("FAIL partial_relock k=%0d: got %0d want %0d", k, t - e0, 2 * S + M + k + 2);
      end
   endtask

   task automatic test_data();
      int v;
      v = 0;
      for (int i = 0; i < 8; i++) begin
         n = (i % 2 == 1) ? 4'hA : 4'h5;
         tick();
         v += int'(DATA_VALID);
      end
      checks++;
      if (DATA !== 8'hA5 || v != 4) begin
         errors++;
         $display("FAIL data_a5: got %0h strobes=%0d want a5/4", DATA, v);
      end
   endtask

   task automatic test_random_data();
      int v;
      v = 0;
      for (int i = 0; i < 40; i++) begin
         n = 4'($urandom);
         tick();
         v += int'(DATA_VALID);
      end
      checks++;
      if (v != 20) begin
         errors++;
         $display("FAIL random_strobes: got %0d want 20", v);
      end
   endtask

   task automatic test_back_to_back();
      int t;
      rot_mode = 1'b0;
      for (int r = 0; r < 3; r++) begin
         n = TRAIN;
         repeat ($urandom_range(0, 3)) tick();
         start_pulse();
         tick();
         checks++;
         if (LOCKED !== 1'b0 || DATA_VALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_leave: got L=%0b V=%0b want 0/0", LOCKED, DATA_VALID);
         end
         wait_lock(30, t);
         checks++;
         if (t - e0 != S + M) begin
            errors++;
            $display("FAIL b2b_lock: got %0d want %0d", t - e0, S + M);
         end
      end
   endtask

   task automatic test_mid_reset();
      int p0;
      rot_mode = 1'b0; n = TRAIN;
      start_pulse();
      repeat (S + 3) tick();
      n = 4'h0;
      #2 RSTN = 1'b0;
      #1;
      exp_data = 8'h00; prev_n = 4'h0; lock_k = 0;
      checks++;
      if ({ALIGNWD, LOCKED, ERR, SLIP_CNT, DATA, DATA_VALID} !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: got %0h want 0", {ALIGNWD, LOCKED, ERR, SLIP_CNT, DATA, DATA_VALID});
      end
      RSTN = 1'b1;
      p0 = pulses;
      repeat (20) tick();
      checks++;
      if (pulses != p0 || {LOCKED, ERR, SLIP_CNT} !== 6'h0) begin
         errors++;
         $display("FAIL post_reset_idle: got pulses=%0d st=%0h want 0/0", pulses - p0, {LOCKED, ERR, SLIP_CNT});
      end
   endtask

   task automatic test_max0();
      int p2;
      n = 4'h0;
      p2 = pulses2;
      start_pulse();
      tick();
      checks++;
      if (er2 !== 1'b0) begin
         errors++;
         $display("FAIL max0_err_early: got %0b want 0", er2);
      end
      tick();
      tick();
      checks++;
      if (er2 !== 1'b1 || lk2 !== 1'b0 || sc2 !== 4'd0 || pulses2 != p2) begin
         errors++;
         $display("FAIL max0_fail: got E=%0b L=%0b cnt=%0d pulses=%0d want 1/0/0/0", er2, lk2, sc2, pulses2 - p2);
      end
      n = TRAIN;
      start_pulse();
      checks++;
      if (er2 !== 1'b0) begin
         errors++;
         $display("FAIL max0_restart: got %0b want 0", er2);
      end
      tick();
      tick();
      checks++;
      if (lk2 !== 1'b1) begin
         errors++;
         $display("FAIL max0_lock: got %0b want 1", lk2);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_settle_ignore();
      test_slips();
      test_fail();
      test_partial(M - 1);
      test_data();
      test_partial($urandom_range(1, M - 1));
      test_random_data();
      test_back_to_back();
      test_mid_reset();
      test_max0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
